// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter feeding a sync FIFO: the winner keeps ownership
// for up to BURST consecutive writes, stalls on full and releases early if it drops req.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int BURST = 4   // legal range 1..15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   din_bus,
    input  logic                 fifo_full,
    output logic [NREQ-1:0]      gnt,
    output logic                 fifo_wr,
    output logic [DW-1:0]        fifo_din,
    output logic                 busy,
    output logic [1:0]           owner
);

    typedef enum logic {IDLE, OWN} state_t;

    localparam logic [3:0] BURST_W = 4'(BURST);

    state_t     state;
    logic [1:0] rr_ptr;
    logic [3:0] wcnt;

    logic       found;
    logic [1:0] winner;
    logic [1:0] idx;
    logic [1:0] sel;
    logic       can_write;

    // Rotating search starting at rr_ptr; first requester found wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
        found  = 1'b0;
        winner = 2'd0;
        idx    = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            idx = rr_ptr + 2'(k);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Only the owner is eligible while a burst is open.
    always_comb begin
        gnt       = '0;
        fifo_wr   = 1'b0;
        fifo_din  = '0;
        sel       = (state == OWN) ? owner : winner;
        can_write = (state == OWN) ? req[owner] : found;
        if (!rst && !fifo_full && can_write) begin
            fifo_wr  = 1'b1;
            gnt[sel] = 1'b1;
            fifo_din = din_bus[sel*DW +: DW];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= 2'd0;
            wcnt   <= 4'd0;
            owner  <= 2'd0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_wr) begin
                        owner <= winner;
                        wcnt  <= 4'd1;
                        if (BURST_W > 4'd1) begin
                            state <= OWN;
                            busy  <= 1'b1;
                        end else begin
                            rr_ptr <= winner + 2'd1;
                        end
                    end
                end
                OWN: begin
                    if (!req[owner]) begin
                        // Owner released early: one bubble cycle, then rearbitrate.
                        state  <= IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= owner + 2'd1;
                    end else if (fifo_wr) begin
                        wcnt <= wcnt + 4'd1;
                        if (wcnt + 4'd1 == BURST_W) begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            rr_ptr <= owner + 2'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4, sets the number of write requesters; fixed at 4 for this release.
REQ-002 Parameter DW, default 8, sets the data width and matches the 16-entry sync FIFO din width.
REQ-003 Parameter BURST, default 4, sets the maximum consecutive writes per grant; legal range 1..15.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  4  req[i]=1: requester i has valid data on din_bus; held until granted.
REQ-007 din_bus  input  4*DW  requester i data at bits [i*DW +: DW].
REQ-008 fifo_full  input  1  full flag from the downstream FIFO.
REQ-009 gnt  output  4  one-hot, combinational; gnt[i]=1 means requester i's word is written this cycle.
REQ-010 fifo_wr  output  1  combinational write strobe to the FIFO.
REQ-011 fifo_din  output  DW  combinational write data to the FIFO.
REQ-012 busy  output  1  registered; 1 while in state OWN.
REQ-013 owner  output  2  registered; index of the current or last owner.

Function
REQ-014 The block SHALL have two states: IDLE and OWN. It SHALL also hold registers rr_ptr[1:0] and wcnt[3:0].
REQ-015 Arbitration in IDLE SHALL search req in order rr_ptr, rr_ptr+1, ... (mod 4). The first set bit wins.
REQ-016 In IDLE, when any req=1 and fifo_full=0, the block SHALL, in the same cycle:
  - assert gnt[winner] and fifo_wr;
  - drive fifo_din with the winner's data;
  - set owner=winner and wcnt=1.
REQ-017 After an IDLE write, the next state SHALL be OWN if BURST>1. If BURST=1, the block SHALL stay IDLE with rr_ptr=winner+1.
REQ-018 In OWN, only req[owner] SHALL be considered. Other requesters SHALL never be granted.
REQ-019 In OWN, when req[owner]=1 and fifo_full=0, the block SHALL write and increment wcnt. If the new wcnt equals BURST, it SHALL go to IDLE with rr_ptr=owner+1.
REQ-020 In OWN, when req[owner]=1 and fifo_full=1, the block SHALL stall:
  - gnt=0 and fifo_wr=0;
  - state and wcnt unchanged.
REQ-021 In OWN, when req[owner]=0, the block SHALL go to IDLE with rr_ptr=owner+1. No grant is issued that cycle (one bubble).
REQ-022 In IDLE, fifo_full=1 SHALL block all grants. State and rr_ptr SHALL be unchanged.
REQ-023 fifo_wr SHALL never be 1 while fifo_full=1. gnt SHALL be nonzero iff fifo_wr=1. gnt SHALL be at most one-hot.
REQ-024 fifo_din SHALL be 0 when fifo_wr=0.
REQ-025 Write order into the FIFO SHALL equal grant order. Data from one requester SHALL stay in its presentation order.
REQ-026 Pointer arithmetic (rr_ptr, owner+1) SHALL wrap modulo 4. wcnt SHALL never exceed BURST.

Reset
REQ-027 While rst=1, the block SHALL force gnt=0, fifo_wr=0 and fifo_din=0, regardless of req or state.
REQ-028 On a clock edge with rst=1, the block SHALL load:
  - state=IDLE, rr_ptr=0, wcnt=0;
  - owner=0, busy=0.
REQ-029 A reset mid-burst SHALL abandon the burst. The first post-reset grant SHALL start a fresh arbitration from rr_ptr=0.

Verification
REQ-030 Reset: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, fifo_wr=0, busy=0, owner=0. The first cycle after release grants requester 0.
REQ-031 Single requester: req=4'b0100 held 6 cycles, BURST=4, FIFO empty -> gnt[2] in 6 consecutive cycles; the FIFO holds 6 words in order.
REQ-032 Round robin: req=4'b1111 held, BURST=4, FIFO initially empty -> grants 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3. fifo_full then rises, and gnt=0 and fifo_wr=0 thereafter.
REQ-033 Full stall: owner=1 with wcnt=2, fifo_full=1 for 3 cycles -> no gnt and busy=1. After full drops, gnt[1] for 2 cycles, then rr_ptr=2.
REQ-034 Owner drop: owner 0 drops req after 2 writes with req[3]=1 -> one cycle with gnt=0, then gnt[3] and owner=3.
REQ-035 Mid-burst reset: rst pulsed for 1 cycle during an owner-2 burst with req=4'b0110 -> gnt=0 in the reset cycle, next grant to requester 1.
